// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - seven-segment display bus reader: debounce, decode, frame assembly
module sevenseg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              bar_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    value_valid,
    output logic [NUM_DIGITS-1:0]   digit_mask,
    output logic                    pattern_err,
    output logic [2:0]              err_digit,
    output logic [7:0]              err_count
);

    localparam int                    SW     = 7 + NUM_DIGITS;
    localparam logic [7:0]            STABLE = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ONE    = NUM_DIGITS'(1);

    logic [SW-1:0]           s;
    logic [7:0]              run;
    logic [4*NUM_DIGITS-1:0] digits;

    logic [SW-1:0]           sample;
    logic                    match;
    logic [7:0]              run_next;
    logic                    accept;
    logic                    onehot;
    logic [2:0]              sel_idx;
    logic [4:0]              dec;
    logic                    frame_done;
    logic [NUM_DIGITS-1:0]   mask_next;

    // Returns {valid, nibble}; anything outside the hex glyph set is invalid.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = 5'h10;
            7'h06:   decode = 5'h11;
            7'h5B:   decode = 5'h12;
            7'h4F:   decode = 5'h13;
            7'h66:   decode = 5'h14;
            7'h6D:   decode = 5'h15;
            7'h7D:   decode = 5'h16;
            7'h07:   decode = 5'h17;
            7'h7F:   decode = 5'h18;
            7'h6F:   decode = 5'h19;
            7'h77:   decode = 5'h1A;
            7'h7C:   decode = 5'h1B;
            7'h39:   decode = 5'h1C;
            7'h5E:   decode = 5'h1D;
            7'h79:   decode = 5'h1E;
            7'h71:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        sample   = {bar_in, digit_sel};
        match    = (sample == s);
        run_next = !match ? 8'd1 : ((run == STABLE) ? run : run + 8'd1);
        // Saturation at STABLE means a held pattern is accepted exactly once.
        accept   = (run_next == STABLE) && (run != STABLE);
        onehot   = (digit_sel != '0) && ((digit_sel & (digit_sel - ONE)) == '0);
        dec      = decode(bar_in);
        sel_idx  = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel[i]) sel_idx = 3'(i);
        end
        frame_done = (digit_mask == '1);
        mask_next  = frame_done ? '0 : digit_mask;
        if (accept && onehot && dec[4]) mask_next = mask_next | digit_sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s           <= '0;
            run         <= '0;
            digits      <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            digit_mask  <= '0;
            pattern_err <= 1'b0;
            err_digit   <= 3'd0;
            err_count   <= 8'd0;
        end else begin
            s           <= sample;
            run         <= run_next;
            value_valid <= 1'b0;
            pattern_err <= 1'b0;
            digit_mask  <= mask_next;
            // Publish the digits as they stood before any capture on this edge.
            if (frame_done) begin
                value       <= digits;
                value_valid <= 1'b1;
            end
            if (accept && onehot) begin
                if (dec[4]) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (digit_sel[i]) digits[i*4 +: 4] <= dec[3:0];
                    end
                end else begin
                    pattern_err <= 1'b1;
                    err_digit   <= sel_idx;
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb/tb_sevenseg_capture.sv - directed self-checking bench for sevenseg_capture
module tb_sevenseg_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  bar_in = 7'h00;
    logic [3:0]  digit_sel = 4'h0;
    logic [15:0] value;
    logic        value_valid;
    logic [3:0]  digit_mask;
    logic        pattern_err;
    logic [2:0]  err_digit;
    logic [7:0]  err_count;

    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] exp_q[$];
    logic [15:0] sb_exp;

    sevenseg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bar_in(bar_in),
        .digit_sel(digit_sel),
        .value(value),
        .value_valid(value_valid),
        .digit_mask(digit_mask),
        .pattern_err(pattern_err),
        .err_digit(err_digit),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] sel, input logic [6:0] pat, input int n);
        digit_sel = sel;
        bar_in    = pat;
        tick(n);
    endtask

    // Scoreboard: every published frame must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (value_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'd0, value_valid}, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_value", {16'd0, value}, {16'd0, sb_exp});
            end
        end
    end

    initial begin
        #1 rst = 1'b0;
        #2;
        check("rst_value", {16'd0, value}, 32'd0);
        check("rst_valid", {31'd0, value_valid}, 32'd0);
        check("rst_mask", {28'd0, digit_mask}, 32'd0);
        check("rst_perr", {31'd0, pattern_err}, 32'd0);
        check("rst_errcnt", {24'd0, err_count}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick(1);

        // Frame 0x4321
        exp_q.push_back(16'h4321);
        show(4'b0001, 7'h06, 4);
        check("f1_mask0", {28'd0, digit_mask}, 32'h1);
        show(4'b0010, 7'h5B, 4);
        check("f1_mask1", {28'd0, digit_mask}, 32'h3);
        show(4'b0100, 7'h4F, 4);
        show(4'b1000, 7'h66, 4);
        check("f1_mask_full", {28'd0, digit_mask}, 32'hF);
        check("f1_valid_early", {31'd0, value_valid}, 32'd0);
        tick(1);
        check("f1_valid", {31'd0, value_valid}, 32'd1);
        check("f1_value", {16'd0, value}, 32'h4321);
        check("f1_mask_clr", {28'd0, digit_mask}, 32'h0);
        tick(1);
        check("f1_valid_pulse", {31'd0, value_valid}, 32'd0);

        // Unstable pattern is not captured; the settled one is
        show(4'b0001, 7'h06, 3);
        check("unstable_mask", {28'd0, digit_mask}, 32'h0);
        show(4'b0001, 7'h7F, 4);
        check("stable_mask", {28'd0, digit_mask}, 32'h1);
        exp_q.push_back(16'h3218);
        show(4'b0010, 7'h06, 4);
        show(4'b0100, 7'h5B, 4);
        show(4'b1000, 7'h4F, 4);
        tick(2);
        check("f2_value", {16'd0, value}, 32'h3218);

        // Invalid pattern on digit 2
        show(4'b0100, 7'h01, 4);
        check("err_pulse", {31'd0, pattern_err}, 32'd1);
        check("err_digit", {29'd0, err_digit}, 32'd2);
        check("err_count1", {24'd0, err_count}, 32'd1);
        check("err_mask", {28'd0, digit_mask}, 32'h0);
        tick(1);
        check("err_pulse_end", {31'd0, pattern_err}, 32'd0);
        tick(5);
        check("err_count_hold", {24'd0, err_count}, 32'd1);

        // Blanking and multi-hot select capture nothing
        show(4'b0000, 7'h06, 10);
        show(4'b0011, 7'h5B, 10);
        check("blank_mask", {28'd0, digit_mask}, 32'h0);
        check("blank_errcnt", {24'd0, err_count}, 32'd1);
        check("blank_perr", {31'd0, pattern_err}, 32'd0);

        // Frame 0xFEDC, then reset in the middle of the next frame
        exp_q.push_back(16'hFEDC);
        show(4'b0001, 7'h39, 4);
        show(4'b0010, 7'h5E, 4);
        show(4'b0100, 7'h79, 4);
        show(4'b1000, 7'h71, 4);
        tick(2);
        check("f3_value", {16'd0, value}, 32'hFEDC);
        show(4'b0001, 7'h3F, 4);
        show(4'b0010, 7'h06, 2);
        check("mid_mask", {28'd0, digit_mask}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_value", {16'd0, value}, 32'd0);
        check("mid_rst_mask", {28'd0, digit_mask}, 32'd0);
        check("mid_rst_errcnt", {24'd0, err_count}, 32'd0);
        check("mid_rst_valid", {31'd0, value_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.push_back(16'hA5B0);
        show(4'b0001, 7'h3F, 4);
        show(4'b0010, 7'h7C, 4);
        show(4'b0100, 7'h6D, 4);
        show(4'b1000, 7'h77, 4);
        tick(2);
        check("f4_value", {16'd0, value}, 32'hA5B0);

        // Error counter saturation
        for (int k = 0; k < 255; k++) begin
            show(4'b0001, (k % 2 == 1) ? 7'h01 : 7'h00, 4);
        end
        check("sat_255", {24'd0, err_count}, 32'd255);
        check("sat_digit", {29'd0, err_digit}, 32'd0);
        show(4'b0001, 7'h08, 4);
        check("sat_pulse", {31'd0, pattern_err}, 32'd1);
        check("sat_hold", {24'd0, err_count}, 32'd255);
        check("sat_mask", {28'd0, digit_mask}, 32'h0);

        tick(2);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Reader side of the multiplexed seven-segment display bus: observes segment lines plus one-hot digit select and reconstructs the hex value shown.
- Filters transient patterns with a stability window and decodes each segment pattern back to a nibble.
- Publishes a full multi-digit value once every digit has been captured in a frame.
- Used for display loop-back checking and for reading counter values back off the display bus.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (2..255).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- bar_in  input  7  segment lines, active-high lit; bit0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g.
- digit_sel  input  NUM_DIGITS  digit enable, bit i = digit i (digit 0 = least significant nibble).
- value  output  4*NUM_DIGITS  last complete decoded value.
- value_valid  output  1  one-cycle pulse when value updates.
- digit_mask  output  NUM_DIGITS  digits captured so far in the current frame.
- pattern_err  output  1  one-cycle pulse on a stable but undecodable pattern.
- err_digit  output  3  index of the digit that caused the last pattern_err.
- err_count  output  8  saturating count of pattern errors.

Behaviour:
- Reset (rst=0, asynchronous): value=0, value_valid=0, digit_mask=0, pattern_err=0, err_digit=0, err_count=0.
- Reset also clears the sample register, run counter and digit capture registers. Deasserting reset mid-frame starts a fresh frame.
- Decode table (gfedcba hex -> nibble): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F. Every other pattern is invalid.
- Sampling, each edge:
  - Sample register s <= {bar_in, digit_sel}.
  - If {bar_in, digit_sel} == s, run <= min(run+1, STABLE_CYCLES); otherwise run <= 1.
- Acceptance happens on the edge where run transitions to STABLE_CYCLES. Only one accept per constant run; saturation prevents repeats.
- At acceptance with digit_sel one-hot (index i):
  - Valid pattern: digit i register <= decoded nibble; digit_mask[i] <= 1.
  - Invalid pattern: pattern_err=1 for one cycle, err_digit <= i, err_count <= err_count+1 (saturates at 255). Digit i is not marked.
- At acceptance with digit_sel zero (blanking) or multi-hot: nothing captured, no error.
- Re-accepting an already-marked digit in the same frame overwrites it (latest wins).
- Frame completion: on the edge after digit_mask becomes all ones:
  - value <= concatenated digit registers; value_valid=1 for that one cycle; digit_mask <= 0.
  - An acceptance on that same edge is recorded into the new frame (mask bit set after clear).
- Latency: inputs first presented before edge E1 and held → digit captured at edge E(STABLE_CYCLES) → value_valid at the following edge if the frame completes.
- value holds between frames; only digit_mask, value_valid and the error outputs move mid-frame.
- Timing: inputs are synchronous to clk; no metastability synchronizer is included.

Test Plan:
- Reset, then hold digit_sel=0001 / bar_in=0x06 for 4 cycles, 0010/0x5B, 0100/0x4F, 1000/0x66, each for 4 cycles → value=0x4321, value_valid one pulse exactly 1 cycle after the 4th accept, digit_mask returns to 0.
- Present digit 0 with 0x06 for 3 cycles, then change to 0x7F → no capture; hold 0x7F 4 cycles → digit_mask=0001, nibble 8.
- Hold digit_sel=0100 with bar_in=0x01 for 10 cycles → single pattern_err pulse, err_digit=2, err_count=1, digit_mask unchanged.
- Hold digit_sel=0000 or 0011 with valid patterns for 10 cycles → no capture, no error.
- Full frame 0xFEDC (0x39, 0x5E, 0x79, 0x71), then rst low mid-second-frame → all outputs 0 immediately; after release a full 0xA5B0 frame decodes correctly.
- Force 256 invalid accepts → err_count saturates at 255.
